// File: rtl/up0628_bus_pkg.sv
// up0628_bus_pkg: address map, TCTL bit positions and address decode shared by the responder and CPU bench
package up0628_bus_pkg;
  localparam logic [5:0] RAM_TOP = 6'h1F;
  localparam logic [5:0] A_GPO   = 6'h30;
  localparam logic [5:0] A_GPI   = 6'h31;
  localparam logic [5:0] A_TCNT  = 6'h32;
  localparam logic [5:0] A_TRLD  = 6'h33;
  localparam logic [5:0] A_TCTL  = 6'h34;
  localparam int TCTL_EN   = 0;
  localparam int TCTL_IE   = 1;
  localparam int TCTL_FLAG = 7;
  typedef enum logic [2:0] {R_RAM, R_GPO, R_GPI, R_TCNT, R_TRLD, R_TCTL, R_RSV} region_t;
  function automatic region_t decode(input logic [5:0] a);
    return a <= RAM_TOP ? R_RAM  :
           a == A_GPO   ? R_GPO  :
           a == A_GPI   ? R_GPI  :
           a == A_TCNT  ? R_TCNT :
           a == A_TRLD  ? R_TRLD :
           a == A_TCTL  ? R_TCTL : R_RSV;
  endfunction
endpackage

// File: rtl/up0628_timer.sv
// up0628_timer: down-counting reload timer with sticky W1C flag and gated interrupt
module up0628_timer
  import up0628_bus_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       we_tcnt,
  input  logic       we_trld,
  input  logic       we_tctl,
  input  logic [7:0] wdata,
  output logic [7:0] tcnt,
  output logic [7:0] trld,
  output logic [7:0] tctl,
  output logic       irq
);
  logic en, ie, flag;
  logic wrap;
  assign wrap = en && tcnt == 8'h00;
  assign tctl = {flag, 5'b0, ie, en};
  assign irq  = flag & ie;
  // Count/reload with CPU writes taking precedence; a terminal count sets FLAG even against a W1C
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tcnt <= 8'h00;
      trld <= 8'h00;
      en   <= 1'b0;
      ie   <= 1'b0;
      flag <= 1'b0;
    end else begin
      tcnt <= we_tcnt ? wdata : !en ? tcnt : wrap ? trld : tcnt - 8'd1;
      if (we_trld) trld <= wdata;
      if (we_tctl) begin
        en <= wdata[TCTL_EN];
        ie <= wdata[TCTL_IE];
      end
      flag <= wrap || (flag && !(we_tctl && wdata[TCTL_FLAG]));
    end
  end
endmodule

// File: rtl/up0628_bus_responder.sv
// up0628_bus_responder: CPU bus slave with 32-byte RAM, GPIO and a reload timer
module up0628_bus_responder
  import up0628_bus_pkg::*;
#(
  parameter int GPI_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [5:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] gpi,
  output logic [7:0] gpo,
  output logic       irq
);
  region_t    rgn;
  logic [7:0] ram  [32];
  logic [7:0] sync [GPI_SYNC_STAGES];
  logic [7:0] tcnt, trld, tctl;
  assign rgn = decode(addr);
  up0628_timer u_timer (
    .clk     (clk),
    .clr_n   (clr_n),
    .we_tcnt (we && rgn == R_TCNT),
    .we_trld (we && rgn == R_TRLD),
    .we_tctl (we && rgn == R_TCTL),
    .wdata   (wdata),
    .tcnt    (tcnt),
    .trld    (trld),
    .tctl    (tctl),
    .irq     (irq)
  );
  // RAM keeps its contents through reset, so it has no reset branch
  always_ff @(posedge clk) begin
    if (we && rgn == R_RAM) ram[addr[4:0]] <= wdata;
  end
  // GPO register and the gpi metastability chain
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      gpo <= 8'h00;
      for (int i = 0; i < GPI_SYNC_STAGES; i++) sync[i] <= 8'h00;
    end else begin
      if (we && rgn == R_GPO) gpo <= wdata;
      sync[0] <= gpi;
      for (int i = 1; i < GPI_SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end
  // Zero-latency read mux; reserved addresses read as zero
  always_comb begin
    rdata = 8'h00;
    case (rgn)
      R_RAM:   rdata = ram[addr[4:0]];
      R_GPO:   rdata = gpo;
      R_GPI:   rdata = sync[GPI_SYNC_STAGES-1];
      R_TCNT:  rdata = tcnt;
      R_TRLD:  rdata = trld;
      R_TCTL:  rdata = tctl;
      default: rdata = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_up0628_bus_responder.sv
// tb_up0628_bus_responder: directed stimulus with a cycle-level reference model and literal checkpoints
module tb_up0628_bus_responder;
  import up0628_bus_pkg::*;
  localparam int S = 2;
  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic [5:0] addr = '0;
  logic       we = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] gpi = '0;
  logic [7:0] rdata, gpo;
  logic       irq;
  int tests = 0;
  int fails = 0;
  bit run = 1'b0;
  up0628_bus_responder #(.GPI_SYNC_STAGES(S)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .gpi   (gpi),
    .gpo   (gpo),
    .irq   (irq)
  );
  always #5 clk = ~clk;
  // reference model state
  logic [7:0] m_ram [32];
  bit         m_vld [32];
  logic [7:0] m_gpo, m_tcnt, m_trld;
  bit         m_en, m_ie, m_flag;
  logic [7:0] m_gpi_q [$];
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_gpo = 0; m_tcnt = 0; m_trld = 0;
    m_en = 0; m_ie = 0; m_flag = 0;
    m_gpi_q.delete();
    repeat (S) m_gpi_q.push_back(8'h00);
  endtask
  task automatic model_step();
    logic [7:0] nt;
    bit nf, w1c;
    w1c = we && addr == A_TCTL && wdata[7];
    nf  = (m_en && m_tcnt == 0) || (m_flag && !w1c);
    if (we && addr == A_TCNT) nt = wdata;
    else if (!m_en) nt = m_tcnt;
    else if (m_tcnt == 0) nt = m_trld;
    else nt = m_tcnt - 8'd1;
    if (we && addr == A_TRLD) m_trld = wdata;
    if (we && addr == A_TCTL) begin m_en = wdata[0]; m_ie = wdata[1]; end
    if (we && addr <= RAM_TOP) begin m_ram[addr[4:0]] = wdata; m_vld[addr[4:0]] = 1; end
    if (we && addr == A_GPO) m_gpo = wdata;
    m_tcnt = nt;
    m_flag = nf;
    m_gpi_q.push_front(gpi);
    void'(m_gpi_q.pop_back());
  endtask
  function automatic logic [7:0] model_rd(input logic [5:0] a);
    if (a <= RAM_TOP) return m_ram[a[4:0]];
    case (a)
      A_GPO:   return m_gpo;
      A_GPI:   return m_gpi_q[S-1];
      A_TCNT:  return m_tcnt;
      A_TRLD:  return m_trld;
      A_TCTL:  return {m_flag, 5'b0, m_ie, m_en};
      default: return 8'h00;
    endcase
  endfunction
  initial begin
    model_reset();
    for (int i = 0; i < 32; i++) m_vld[i] = 0;
  end
  always @(negedge clr_n) model_reset();
  always @(posedge clk) if (clr_n) model_step();
  // per-cycle comparison against the model after each edge settles
  always @(posedge clk) begin
    #2;
    if (run && clr_n) begin
      if (!(addr <= RAM_TOP && !m_vld[addr[4:0]])) chk("model_rdata", rdata, model_rd(addr));
      chk("model_gpo", gpo, m_gpo);
      chk("model_irq", {7'b0, irq}, {7'b0, m_flag && m_ie});
    end
  end
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; we = 1'b1; wdata = d;
  endtask
  task automatic rd_chk(input logic [5:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    addr = a; we = 1'b0;
    #1 chk(name, rdata, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit found;
    #1 clr_n = 1'b0;
    addr = A_TCNT;
    #1 chk("rst_gpo", gpo, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_tcnt", rdata, 8'h00);
    addr = A_TCTL;
    #1 chk("rst_tctl", rdata, 8'h00);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    run = 1'b1;
    // RAM and reserved space
    wr(6'h00, 8'hA5);
    wr(6'h1F, 8'h5A);
    rd_chk(6'h00, 8'hA5, "ram_lo");
    rd_chk(6'h1F, 8'h5A, "ram_hi");
    rd_chk(6'h20, 8'h00, "rsv_20");
    wr(6'h20, 8'hFF);
    wr(6'h35, 8'hFF);
    wr(6'h3F, 8'hFF);
    rd_chk(6'h20, 8'h00, "rsv_wr_20");
    rd_chk(6'h35, 8'h00, "rsv_wr_35");
    rd_chk(6'h3F, 8'h00, "rsv_wr_3f");
    // GPIO
    wr(A_GPO, 8'h3C);
    @(negedge clk);
    addr = A_GPO; we = 1'b0; gpi = 8'h81;
    #1 chk("gpo_out", gpo, 8'h3C);
    chk("gpo_rd", rdata, 8'h3C);
    addr = A_GPI;
    #1 chk("gpi_0edge", rdata, 8'h00);
    @(posedge clk);
    #1 chk("gpi_1edge", rdata, 8'h00);
    @(posedge clk);
    #1 chk("gpi_2edge", rdata, 8'h81);
    wr(A_GPI, 8'hFF);
    rd_chk(A_GPI, 8'h81, "gpi_ro");
    // timer period, irq and W1C
    wr(A_TRLD, 8'h03);
    wr(A_TCNT, 8'h00);
    wr(A_TCTL, 8'h03);
    rd_chk(A_TCTL, 8'h03, "tctl_en");
    @(posedge clk);
    #1 chk("flag_first", rdata, 8'h83);
    chk("irq_first", {7'b0, irq}, 8'h01);
    wr(A_TCTL, 8'h83);
    rd_chk(A_TCTL, 8'h03, "w1c_clear");
    chk("irq_cleared", {7'b0, irq}, 8'h00);
    @(posedge clk);
    #1 chk("period_c2", rdata, 8'h03);
    @(posedge clk);
    #1 chk("period_c3", rdata, 8'h03);
    @(posedge clk);
    #1 chk("period_c4", rdata, 8'h83);
    chk("irq_period", {7'b0, irq}, 8'h01);
    // W1C colliding with a reload edge
    wr(A_TCTL, 8'h83);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      addr = A_TCNT; we = 1'b0;
      #1 if (rdata == 8'h00) begin
        addr = A_TCTL; we = 1'b1; wdata = 8'h83; found = 1;
      end
    end
    chk("poll_tcnt0", {7'b0, found}, 8'h01);
    rd_chk(A_TCTL, 8'h83, "w1c_collide");
    chk("irq_collide", {7'b0, irq}, 8'h01);
    // CPU write beats decrement, then disable holds the count
    wr(A_TCNT, 8'h10);
    rd_chk(A_TCNT, 8'h10, "tcnt_wr_prio");
    wr(A_TCTL, 8'h82);
    rd_chk(A_TCNT, 8'h0E, "tcnt_en_off");
    repeat (3) @(negedge clk);
    rd_chk(A_TCNT, 8'h0E, "tcnt_hold");
    rd_chk(A_TCTL, 8'h02, "tctl_disabled");
    chk("irq_disabled", {7'b0, irq}, 8'h00);
    // TRLD=0 sets FLAG every cycle, overriding repeated W1C
    wr(A_TRLD, 8'h00);
    wr(A_TCNT, 8'h00);
    wr(A_TCTL, 8'h03);
    repeat (3) wr(A_TCTL, 8'h83);
    rd_chk(A_TCTL, 8'h83, "trld0_flag");
    rd_chk(A_TCNT, 8'h00, "trld0_tcnt");
    // asynchronous reset mid-operation
    wr(6'h05, 8'h77);
    wr(A_GPO, 8'hFF);
    @(negedge clk);
    we = 1'b0; addr = A_TCNT;
    #1 chk("pre_rst_gpo", gpo, 8'hFF);
    chk("pre_rst_irq", {7'b0, irq}, 8'h01);
    #1 clr_n = 1'b0;
    #1 chk("mid_rst_gpo", gpo, 8'h00);
    chk("mid_rst_irq", {7'b0, irq}, 8'h00);
    chk("mid_rst_tcnt", rdata, 8'h00);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    rd_chk(A_TCNT, 8'h00, "post_rst_tcnt");
    rd_chk(6'h05, 8'h77, "post_rst_ram");
    rd_chk(6'h00, 8'hA5, "post_rst_ram0");
    rd_chk(A_TCTL, 8'h00, "post_rst_tctl");
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/up0628_bus_responder.md
UP0628_BUS_RESPONDER -- requirements
Module: up0628_bus_responder

Interface
REQ-001 SHALL have parameter GPI_SYNC_STAGES, default 2: number of flip-flop stages in the gpi synchronizer, legal range 2..3.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port addr  input  6  CPU bus address.
REQ-005 SHALL have port we  input  1  CPU write strobe, active high.
REQ-006 SHALL have port wdata  input  8  CPU write data, driven from the CPU data_out.
REQ-007 SHALL have port rdata  output  8  read data returned to the CPU data_in.
REQ-008 SHALL have port gpi  input  8  asynchronous general-purpose inputs.
REQ-009 SHALL have port gpo  output  8  general-purpose output register.
REQ-010 SHALL have port irq  output  1  timer interrupt request, level, active high.

Function
REQ-011 SHALL decode the address map as follows:
 - 0x00-0x1F: RAM, 32x8.
 - 0x30: GPO (R/W).
 - 0x31: GPI (RO).
 - 0x32: TCNT (R/W).
 - 0x33: TRLD (R/W).
 - 0x34: TCTL (R/W).
 - All other addresses: reserved.
REQ-012 SHALL perform reads combinationally: rdata reflects addr in the same cycle, with zero-cycle latency.
REQ-013 SHALL commit a write on the rising clk edge when we=1; the written value SHALL be readable in the next cycle.
REQ-014 SHALL return 0x00 on reads of reserved addresses and SHALL ignore writes to them.
REQ-015 SHALL make GPI read the output of the final synchronizer stage, so a gpi change is visible after GPI_SYNC_STAGES edges.
REQ-016 SHALL ignore writes to GPI.
REQ-017 SHALL lay out TCTL as follows:
 - bit0 EN.
 - bit1 IE.
 - bit7 FLAG (read-only, write-1-to-clear).
 - bits6:2 read as 0.
REQ-018 SHALL make a TCTL write load EN from wdata[0] and IE from wdata[1]; wdata[7]=1 SHALL clear FLAG.
REQ-019 SHALL decrement TCNT by 1 each cycle while EN=1 and TCNT!=0.
REQ-020 SHALL, while EN=1 and TCNT==0, load TCNT from TRLD and set FLAG on the same edge.
REQ-021 SHALL make a CPU write to TCNT take priority over a decrement or reload on the same edge.
REQ-022 SHALL let FLAG set win over a simultaneous W1C clear on the same edge.
REQ-023 SHALL, with TRLD=N, produce a timer period of N+1 cycles; with TRLD=0, FLAG SHALL set every cycle while EN=1.
REQ-024 SHALL hold TCNT at its value when EN=0 and SHALL not set FLAG.
REQ-025 SHALL drive irq = FLAG AND IE, combinationally from registers.
REQ-026 SHALL perform all arithmetic unsigned 8-bit; there is no underflow past 0 (reload instead).

Reset
REQ-027 SHALL, while clr_n=0 and regardless of clk, asynchronously reset the following to 0x00 / 0:
 - GPO, TCNT, TRLD.
 - EN, IE, FLAG.
 - all synchronizer stages.
REQ-028 SHALL NOT reset RAM; RAM contents SHALL be undefined after power-up and preserved across clr_n assertion.
REQ-029 SHALL, when reset is asserted mid-count, abort the count immediately and drive irq=0 in the same cycle clr_n falls.
REQ-030 SHALL, on clr_n deassertion, resume normal operation from the first rising edge after deassertion.

Structure
REQ-031 SHALL place address constants (RAM_TOP, A_GPO, A_GPI, A_TCNT, A_TRLD, A_TCTL) and TCTL bit indices in package up0628_bus_pkg, shared with the CPU bench.
REQ-032 SHALL implement the timer (TCNT, TRLD, EN, IE, FLAG, irq) as sub-module up0628_timer; address decode, RAM, GPIO and the read mux SHALL remain in the top.
REQ-033 SHALL infer RAM as flip-flops or a latch-free register array with an asynchronous read port.

Verification
REQ-034 SHALL cover RAM: write 0xA5 @0x00 and 0x5A @0x1F, then read both -> rdata 0xA5 and 0x5A; read 0x20 -> 0x00.
REQ-035 SHALL cover GPIO: write 0x3C @0x30 -> gpo=0x3C next cycle; drive gpi=0x81 -> read @0x31 returns 0x81 after exactly 2 edges, and the old value before that.
REQ-036 SHALL cover the timer:
 - Write TRLD=3, TCNT=0, TCTL=0x03.
 - -> FLAG sets 1 edge later, then every 4 cycles.
 - irq=1 while FLAG=1.
 - Writing TCTL=0x83 clears FLAG and drops irq.
REQ-037 SHALL cover timer collisions:
 - W1C on the same edge TCNT reaches reload -> FLAG remains 1.
 - TCNT write of 0x10 on a decrement edge -> TCNT reads 0x10.
REQ-038 SHALL cover reset mid-operation:
 - Setup: running timer with irq=1 and gpo=0xFF.
 - Assert clr_n=0 between edges -> gpo=0x00 and irq=0 immediately.
 - TCNT reads 0x00 after release.
 - A RAM byte written before reset still reads back its value.
